// File: rtl/adc_sched_pkg.sv
// Shared state encoding and default timing constants for the ADC pair read scheduler.
package adc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RST_ASSERT = 3'd1,
    RST_WAIT   = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } sched_state_t;

  localparam int CNT_W           = 8;
  localparam int DEF_RST_CYCLES  = 8;
  localparam int DEF_WAIT_CYCLES = 32;
  localparam int DEF_SKEW_LIMIT  = 16;

endpackage

// File: rtl/sched_down_counter.sv
// 8-bit phase/run-length counter: load, step down (or up when 'up' is set), zero flag.
module sched_down_counter
  import adc_sched_pkg::*;
(
  input  logic             alg_clk,
  input  logic             alg_rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             step,
  input  logic             up,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge alg_clk) begin
    if (!alg_rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step) begin
      count <= up ? count + 8'd1 : count - 8'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/adc_pair_read_scheduler.sv
// Read-side sequencer for the A/B ADC CDC FIFO pair: resets and settles the FIFOs,
// then issues lock-step paired reads and flags skew or overflow.
module adc_pair_read_scheduler
  import adc_sched_pkg::*;
#(
  parameter int DW          = 16,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int SKEW_LIMIT  = DEF_SKEW_LIMIT
) (
  input  logic          alg_clk,
  input  logic          alg_rst_n,
  input  logic          enable,
  input  logic          empty_a,
  input  logic          empty_b,
  input  logic          full_a,
  input  logic          full_b,
  input  logic [DW-1:0] dout_a,
  input  logic [DW-1:0] dout_b,
  output logic          fifo_rst,
  output logic          rd_en_a,
  output logic          rd_en_b,
  output logic [DW-1:0] pair_a,
  output logic [DW-1:0] pair_b,
  output logic          pair_valid,
  output logic          skew_err,
  output logic          ovf_err,
  output logic          busy,
  output logic [31:0]   pair_cnt
);

  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SKEW_LAST = CNT_W'(SKEW_LIMIT - 1);

  sched_state_t     state;
  logic             rd_pend;
  logic             phase_load, phase_step, phase_zero;
  logic [CNT_W-1:0] phase_val;
  logic [CNT_W-1:0] phase_cnt_unused;
  logic             skew_load, skew_step, skew_zero_unused;
  logic [CNT_W-1:0] skew_cnt;
  logic             skew_mis, skew_hit, ovf_hit, rd_go;

  // Phase counter is preloaded with N-1 so each phase lasts exactly N cycles.
  always_comb begin
    phase_load = 1'b0;
    phase_val  = '0;
    phase_step = 1'b0;
    case (state)
      IDLE: begin
        phase_load = enable;
        phase_val  = RST_LOAD;
      end
      RST_ASSERT: begin
        phase_load = phase_zero;
        phase_val  = WAIT_LOAD;
        phase_step = !phase_zero;
      end
      RST_WAIT: phase_step = !phase_zero;
      default: ;
    endcase
  end

  assign skew_mis  = empty_a ^ empty_b;
  assign skew_load = (state != RUN) || !skew_mis;
  assign skew_step = (state == RUN) && skew_mis;
  assign skew_hit  = skew_step && (skew_cnt == SKEW_LAST);
  assign ovf_hit   = (state == RUN) && (full_a || full_b);
  assign rd_go     = !empty_a && !empty_b && !rd_en_a;

  sched_down_counter u_phase_cnt (
    .alg_clk  (alg_clk),
    .alg_rst_n(alg_rst_n),
    .load     (phase_load),
    .load_val (phase_val),
    .step     (phase_step),
    .up       (1'b0),
    .count    (phase_cnt_unused),
    .zero     (phase_zero)
  );

  sched_down_counter u_skew_cnt (
    .alg_clk  (alg_clk),
    .alg_rst_n(alg_rst_n),
    .load     (skew_load),
    .load_val ('0),
    .step     (skew_step),
    .up       (1'b1),
    .count    (skew_cnt),
    .zero     (skew_zero_unused)
  );

  // The read pipeline runs independently of state so an issued read always lands.
  always_ff @(posedge alg_clk) begin
    if (!alg_rst_n) begin
      state      <= IDLE;
      fifo_rst   <= 1'b0;
      rd_en_a    <= 1'b0;
      rd_en_b    <= 1'b0;
      rd_pend    <= 1'b0;
      pair_a     <= '0;
      pair_b     <= '0;
      pair_valid <= 1'b0;
      skew_err   <= 1'b0;
      ovf_err    <= 1'b0;
      busy       <= 1'b0;
      pair_cnt   <= '0;
    end else begin
      rd_en_a    <= 1'b0;
      rd_en_b    <= 1'b0;
      pair_valid <= 1'b0;
      rd_pend    <= rd_en_a;
      if (rd_pend) begin
        pair_a     <= dout_a;
        pair_b     <= dout_b;
        pair_valid <= 1'b1;
        pair_cnt   <= pair_cnt + 32'd1;
      end
      case (state)
        IDLE: if (enable) begin
          state    <= RST_ASSERT;
          fifo_rst <= 1'b1;
          busy     <= 1'b1;
          skew_err <= 1'b0;
          ovf_err  <= 1'b0;
          pair_cnt <= '0;
        end
        RST_ASSERT: if (!enable) begin
          state    <= IDLE;
          fifo_rst <= 1'b0;
          busy     <= 1'b0;
        end else if (phase_zero) begin
          state    <= RST_WAIT;
          fifo_rst <= 1'b0;
        end
        RST_WAIT: if (!enable) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (phase_zero) begin
          state <= RUN;
        end
        RUN: if (skew_hit || ovf_hit) begin
          state    <= FAULT;
          busy     <= 1'b0;
          skew_err <= skew_err | skew_hit;
          ovf_err  <= ovf_err | ovf_hit;
        end else if (!enable) begin
          if (!rd_en_a && !rd_pend) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else if (rd_go) begin
          rd_en_a <= 1'b1;
          rd_en_b <= 1'b1;
        end
        FAULT: if (!enable) state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_pair_read_scheduler.sv
// Directed bench for adc_pair_read_scheduler: FIFO-pair model, cycle-level reference model, per-cycle compare.
module tb_adc_pair_read_scheduler;

  localparam int DW    = 16;
  localparam int RSTC  = 8;
  localparam int WAITC = 32;
  localparam int SKEWL = 16;

  localparam int M_IDLE  = 0;
  localparam int M_SEQ   = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAULT = 3;

  logic          alg_clk = 1'b0;
  logic          alg_rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          full_a = 1'b0, full_b = 1'b0;
  logic          man_on = 1'b0, man_empty_a = 1'b1, man_empty_b = 1'b1;
  logic          fe_a = 1'b1, fe_b = 1'b1;
  logic          empty_a, empty_b;
  logic [DW-1:0] dout_a = '0, dout_b = '0;
  logic          fifo_rst, rd_en_a, rd_en_b, pair_valid, skew_err, ovf_err, busy;
  logic [DW-1:0] pair_a, pair_b;
  logic [31:0]   pair_cnt;

  int checks = 0;
  int failures = 0;

  adc_pair_read_scheduler dut (
    .alg_clk   (alg_clk),
    .alg_rst_n (alg_rst_n),
    .enable    (enable),
    .empty_a   (empty_a),
    .empty_b   (empty_b),
    .full_a    (full_a),
    .full_b    (full_b),
    .dout_a    (dout_a),
    .dout_b    (dout_b),
    .fifo_rst  (fifo_rst),
    .rd_en_a   (rd_en_a),
    .rd_en_b   (rd_en_b),
    .pair_a    (pair_a),
    .pair_b    (pair_b),
    .pair_valid(pair_valid),
    .skew_err  (skew_err),
    .ovf_err   (ovf_err),
    .busy      (busy),
    .pair_cnt  (pair_cnt)
  );

  always #5 alg_clk = ~alg_clk;

  assign empty_a = man_on ? man_empty_a : fe_a;
  assign empty_b = man_on ? man_empty_b : fe_b;

  // FIFO pair: data appears on dout the cycle after a read strobe; empty follows the pop.
  logic [DW-1:0] fa[$], fb[$];
  always @(posedge alg_clk) begin
    if (fifo_rst) begin
      fa.delete();
      fb.delete();
    end else begin
      if (rd_en_a && fa.size() > 0) dout_a <= fa.pop_front();
      if (rd_en_b && fb.size() > 0) dout_b <= fb.pop_front();
    end
    fe_a <= (fa.size() == 0);
    fe_b <= (fb.size() == 0);
  end

  // Reference model: elapsed-cycle sequencing and a queue of pairs due at future cycles.
  typedef struct {
    int            t;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } due_t;

  due_t          due[$];
  logic [DW-1:0] ra[$], rb[$];
  int            cyc = 0, m_mode = M_IDLE, k = 0, srun = 0;
  bit            last_rd = 0, cmp_on = 0;
  logic          e_fifo_rst = 0, e_rd = 0, e_valid = 0, e_skew = 0, e_ovf = 0, e_busy = 0;
  logic [DW-1:0] e_pa = '0, e_pb = '0;
  logic [31:0]   e_cnt = '0;

  always @(posedge alg_clk) begin
    bit outstanding, rd, sk, ov;
    due_t d;
    cyc++;
    if (!alg_rst_n) begin
      m_mode = M_IDLE; last_rd = 0; due.delete();
      e_fifo_rst = 0; e_rd = 0; e_valid = 0; e_skew = 0; e_ovf = 0; e_busy = 0;
      e_pa = '0; e_pb = '0; e_cnt = '0;
      cmp_on = 1;
    end else begin
      outstanding = last_rd || (due.size() > 0);
      e_valid = 0;
      if (due.size() > 0 && due[0].t == cyc) begin
        d = due.pop_front();
        e_pa = d.a; e_pb = d.b; e_valid = 1; e_cnt = e_cnt + 32'd1;
      end
      rd = 0;
      case (m_mode)
        M_IDLE: if (enable) begin
          m_mode = M_SEQ; k = 0; e_skew = 0; e_ovf = 0; e_cnt = '0;
        end
        M_SEQ: if (!enable) m_mode = M_IDLE;
          else begin
            k++;
            if (k == RSTC + WAITC) begin m_mode = M_RUN; srun = 0; end
          end
        M_RUN: begin
          srun = (empty_a != empty_b) ? srun + 1 : 0;
          sk = (srun >= SKEWL);
          ov = full_a || full_b;
          if (sk || ov) begin
            m_mode = M_FAULT; e_skew = e_skew | sk; e_ovf = e_ovf | ov;
          end else if (!enable) begin
            if (!outstanding) m_mode = M_IDLE;
          end else if (!empty_a && !empty_b && !last_rd) begin
            rd = 1;
            d.t = cyc + 2;
            d.a = (ra.size() > 0) ? ra.pop_front() : e_pa;
            d.b = (rb.size() > 0) ? rb.pop_front() : e_pb;
            due.push_back(d);
          end
        end
        default: if (!enable) m_mode = M_IDLE;
      endcase
      last_rd    = rd;
      e_rd       = rd;
      e_fifo_rst = (m_mode == M_SEQ) && (k < RSTC);
      e_busy     = (m_mode == M_SEQ) || (m_mode == M_RUN);
      if (e_fifo_rst) begin ra.delete(); rb.delete(); end
    end
  end

  // Every cycle after the first reset edge, the DUT outputs must match the model.
  always @(negedge alg_clk) begin
    logic [70:0] act, exp;
    if (cmp_on) begin
      act = {fifo_rst, rd_en_a, rd_en_b, pair_valid, skew_err, ovf_err, busy, pair_cnt, pair_a, pair_b};
      exp = {e_fifo_rst, e_rd, e_rd, e_valid, e_skew, e_ovf, e_busy, e_cnt, e_pa, e_pb};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("[TB] FAIL cycle_compare cyc=%0d act=%h exp=%h", cyc, act, exp);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_n_v, input logic en_v);
    alg_rst_n = rst_n_v;
    enable    = en_v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge alg_clk);
  endtask

  task automatic loadWords(input logic [DW-1:0] a0, input logic [DW-1:0] b0, input int n);
    for (int i = 0; i < n; i++) begin
      fa.push_back(a0 + DW'(i)); ra.push_back(a0 + DW'(i));
      fb.push_back(b0 + DW'(i)); rb.push_back(b0 + DW'(i));
    end
  endtask

  task automatic waitRd(input string name);
    int n;
    n = 0;
    while (rd_en_a !== 1'b1 && n < 12) begin tick(1); n++; end
    checkOutput(name, {31'd0, rd_en_a}, 32'd1);
  endtask

  initial begin
    int hi, lo, bz, rds, pvs, first;
    int rd_t[8], pv_t[8];
    logic [DW-1:0] pa[8], pb[8];

    $display("[TB] start");
    // Reset, then the FIFO reset/settle sequence
    applyStimulus(0, 0);
    tick(2);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_fifo_rst", {31'd0, fifo_rst}, 32'd0);
    checkOutput("reset_pair_cnt", pair_cnt, 32'd0);
    applyStimulus(1, 1);
    hi = 0; lo = 0; bz = 0; rds = 0;
    for (int i = 0; i < RSTC + WAITC; i++) begin
      tick(1);
      if (fifo_rst) hi++; else lo++;
      if (busy) bz++;
      if (rd_en_a || rd_en_b) rds++;
    end
    checkOutput("seq_rst_cycles", hi, 8);
    checkOutput("seq_wait_cycles", lo, 32);
    checkOutput("seq_busy_cycles", bz, 40);
    checkOutput("seq_no_reads", rds, 0);

    // Four aligned pairs
    loadWords(16'h0001, 16'h1001, 4);
    rds = 0; pvs = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (rd_en_a && rds < 8) begin rd_t[rds] = i; rds++; end
      if (pair_valid && pvs < 8) begin pv_t[pvs] = i; pa[pvs] = pair_a; pb[pvs] = pair_b; pvs++; end
    end
    checkOutput("run_rd_count", rds, 4);
    checkOutput("run_pv_count", pvs, 4);
    for (int i = 0; i < 4 && i < rds && i < pvs; i++) begin
      checkOutput($sformatf("pair_a_%0d", i), {16'd0, pa[i]}, 32'h0001 + i);
      checkOutput($sformatf("pair_b_%0d", i), {16'd0, pb[i]}, 32'h1001 + i);
      checkOutput($sformatf("pv_latency_%0d", i), pv_t[i] - rd_t[i], 2);
      if (i > 0) checkOutput($sformatf("rd_gap_%0d", i), rd_t[i] - rd_t[i-1], 2);
    end
    checkOutput("run_pair_cnt", pair_cnt, 32'd4);

    // Channel skew: A has data, B stays empty
    man_on = 1; man_empty_a = 0; man_empty_b = 1;
    first = 0; rds = 0;
    for (int i = 1; i <= 30 && first == 0; i++) begin
      tick(1);
      if (rd_en_a) rds++;
      if (skew_err) first = i;
    end
    checkOutput("skew_cycle", first, 16);
    checkOutput("skew_no_reads", rds, 0);
    checkOutput("skew_fault_busy", {31'd0, busy}, 32'd0);
    man_empty_a = 1;
    applyStimulus(1, 0);
    tick(2);
    checkOutput("skew_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("skew_sticky", {31'd0, skew_err}, 32'd1);

    // Overflow while both FIFOs look readable
    man_on = 0;
    applyStimulus(1, 1);
    tick(RSTC + WAITC + 1);
    checkOutput("restart_skew_clear", {31'd0, skew_err}, 32'd0);
    checkOutput("restart_run_busy", {31'd0, busy}, 32'd1);
    man_on = 1; man_empty_a = 0; man_empty_b = 0; full_b = 1;
    tick(1);
    full_b = 0;
    checkOutput("ovf_set", {31'd0, ovf_err}, 32'd1);
    rds = 0;
    for (int i = 0; i < 3; i++) begin
      if (rd_en_a || rd_en_b) rds++;
      tick(1);
    end
    checkOutput("ovf_no_reads", rds, 0);
    applyStimulus(1, 0);
    tick(1);
    checkOutput("ovf_sticky_idle", {31'd0, ovf_err}, 32'd1);
    man_on = 0;
    applyStimulus(1, 1);
    tick(1);
    checkOutput("ovf_cleared", {31'd0, ovf_err}, 32'd0);
    checkOutput("ovf_restart_rst", {31'd0, fifo_rst}, 32'd1);
    tick(RSTC + WAITC);

    // Synchronous reset with a read in flight
    loadWords(16'h00C1, 16'h10C1, 2);
    waitRd("inflight_rd_seen");
    applyStimulus(0, 1);
    tick(1);
    checkOutput("midrst_rd_en", {30'd0, rd_en_a, rd_en_b}, 32'd0);
    checkOutput("midrst_pair_a", {16'd0, pair_a}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1, 1);
    pvs = 0;
    for (int i = 0; i < 4; i++) begin tick(1); if (pair_valid) pvs++; end
    checkOutput("midrst_no_pv", pvs, 0);

    // enable drops in the same cycle as a read strobe
    tick(RSTC + WAITC);
    loadWords(16'h00A1, 16'h10A1, 2);
    waitRd("drain_rd_seen");
    applyStimulus(1, 0);
    pvs = 0; rds = 0; pa[0] = '0; pb[0] = '0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (rd_en_a) rds++;
      if (pair_valid) begin pvs++; pa[0] = pair_a; pb[0] = pair_b; end
    end
    checkOutput("drain_pv_count", pvs, 1);
    checkOutput("drain_no_more_rd", rds, 0);
    checkOutput("drain_pair_a", {16'd0, pa[0]}, 32'h00A1);
    checkOutput("drain_pair_b", {16'd0, pb[0]}, 32'h10A1);
    checkOutput("drain_pair_cnt", pair_cnt, 32'd1);
    checkOutput("drain_idle_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog act=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
